// File: rtl/hazard_unit_if.sv
// Decode-side metadata and hazard controls between D stage and hazard_unit.
// master = pipeline/decode side, slave = hazard_unit.
interface hazard_unit_if;
  logic [4:0] dec_read_addr0;
  logic [4:0] dec_read_addr1;
  logic [1:0] dec_read_stage0;
  logic [1:0] dec_read_stage1;
  logic [4:0] dec_write_addr;
  logic [1:0] dec_write_stage;
  logic       stall;
  logic [1:0] fwd_d0;
  logic [1:0] fwd_d1;
  logic [1:0] fwd_e0;
  logic [1:0] fwd_e1;
  logic [1:0] fwd_m1;

  modport master (
    output dec_read_addr0, dec_read_addr1,
    output dec_read_stage0, dec_read_stage1,
    output dec_write_addr, dec_write_stage,
    input  stall, fwd_d0, fwd_d1,
    input  fwd_e0, fwd_e1, fwd_m1
  );

  modport slave (
    input  dec_read_addr0, dec_read_addr1,
    input  dec_read_stage0, dec_read_stage1,
    input  dec_write_addr, dec_write_stage,
    output stall, fwd_d0, fwd_d1,
    output fwd_e0, fwd_e1, fwd_m1
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall/forward controller tracking writers in E, M, W slots.
// Optional HAZARD_STAT_EN adds a saturating stall_count output.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  hazard_unit_if.slave hz
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam logic [1:0] STAGE_DECODE  = 2'd0;
  localparam logic [1:0] STAGE_EXECUTE = 2'd1;
  localparam logic [1:0] STAGE_MEM     = 2'd2;
  localparam logic [1:0] STAGE_MAX     = 2'd3;

  logic [4:0] e_wa, e_ra0, e_ra1;
  logic [1:0] e_ws;
  logic [4:0] m_wa, m_ra1;
  logic [1:0] m_ws;
  logic [4:0] w_wa;
  logic [1:0] w_ws;

  logic [1:0] nd0, nd1, ne0, ne1, nm1;
  logic       stall_w;

  // Nearest slot above stage c writing r; 0 = no match.
  function automatic logic [1:0] near(
    input logic [4:0] r,
    input logic [1:0] c,
    input logic [4:0] ea,
    input logic [4:0] ma,
    input logic [4:0] wa
  );
    near = STAGE_DECODE;
    if (r != 5'd0) begin
      if (c < STAGE_EXECUTE && ea == r)
        near = STAGE_EXECUTE;
      else if (c < STAGE_MEM && ma == r)
        near = STAGE_MEM;
      else if (wa == r)
        near = STAGE_MAX;
    end
  endfunction

  function automatic logic [1:0] ws_at(
    input logic [1:0] p,
    input logic [1:0] es,
    input logic [1:0] ms,
    input logic [1:0] wsv
  );
    unique case (p)
      STAGE_EXECUTE: ws_at = es;
      STAGE_MEM:     ws_at = ms;
      STAGE_MAX:     ws_at = wsv;
      default:       ws_at = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] sel(
    input logic [1:0] p,
    input logic [1:0] wsp
  );
    sel = (p != 2'd0 && p > wsp) ? p : 2'd0;
  endfunction

  // Only E/M producers can stall; W is always forwardable to D.
  function automatic logic hit(
    input logic [1:0] p,
    input logic [1:0] u,
    input logic [1:0] wsp
  );
    hit = (u != STAGE_MAX)
       && (p == STAGE_EXECUTE || p == STAGE_MEM)
       && ({1'b0, wsp} >= ({1'b0, u} + {1'b0, p}));
  endfunction

  always_comb begin
    nd0 = near(hz.dec_read_addr0, STAGE_DECODE,
               e_wa, m_wa, w_wa);
    nd1 = near(hz.dec_read_addr1, STAGE_DECODE,
               e_wa, m_wa, w_wa);
    ne0 = near(e_ra0, STAGE_EXECUTE, e_wa, m_wa, w_wa);
    ne1 = near(e_ra1, STAGE_EXECUTE, e_wa, m_wa, w_wa);
    nm1 = near(m_ra1, STAGE_MEM, e_wa, m_wa, w_wa);

    hz.fwd_d0 = sel(nd0, ws_at(nd0, e_ws, m_ws, w_ws));
    hz.fwd_d1 = sel(nd1, ws_at(nd1, e_ws, m_ws, w_ws));
    hz.fwd_e0 = sel(ne0, ws_at(ne0, e_ws, m_ws, w_ws));
    hz.fwd_e1 = sel(ne1, ws_at(ne1, e_ws, m_ws, w_ws));
    hz.fwd_m1 = sel(nm1, ws_at(nm1, e_ws, m_ws, w_ws));

    stall_w = hit(nd0, hz.dec_read_stage0,
                  ws_at(nd0, e_ws, m_ws, w_ws))
            | hit(nd1, hz.dec_read_stage1,
                  ws_at(nd1, e_ws, m_ws, w_ws));
    hz.stall = stall_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_wa  <= '0;
      e_ws  <= '0;
      e_ra0 <= '0;
      e_ra1 <= '0;
      m_wa  <= '0;
      m_ws  <= '0;
      m_ra1 <= '0;
      w_wa  <= '0;
      w_ws  <= '0;
    end else begin
      w_wa  <= m_wa;
      w_ws  <= m_ws;
      m_wa  <= e_wa;
      m_ws  <= e_ws;
      m_ra1 <= e_ra1;
      if (stall_w) begin
        e_wa  <= '0;
        e_ws  <= '0;
        e_ra0 <= '0;
        e_ra1 <= '0;
      end else begin
        e_wa  <= hz.dec_write_addr;
        e_ws  <= hz.dec_write_stage;
        e_ra0 <= hz.dec_read_addr0;
        e_ra1 <= hz.dec_read_addr1;
      end
    end
  end

`ifdef HAZARD_STAT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (stall_w && stall_count != 32'hFFFF_FFFF)
      stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: instruction-level model vs DUT.
// Directed hazard cases, mid-stall reset, then random streams.
module tb_hazard_unit;

  typedef struct packed {
    logic [4:0] ra0;
    logic [1:0] u0;
    logic [4:0] ra1;
    logic [1:0] u1;
    logic [4:0] wa;
    logic [1:0] ws;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  d0;
    logic [1:0]  d1;
    logic [1:0]  e0;
    logic [1:0]  e1;
    logic [1:0]  m1;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  hazard_unit_if hif ();
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_count;
`endif

  hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
`ifdef HAZARD_STAT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  instr_t iq[$];
  instr_t pipe[1:3];
  longint mcnt;
  exp_t mx;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  function automatic instr_t mk(int ra0, int u0, int ra1,
                                int u1, int wa, int ws);
    instr_t i;
    i.ra0 = 5'(ra0);
    i.u0  = 2'(u0);
    i.ra1 = 5'(ra1);
    i.u1  = 2'(u1);
    i.wa  = 5'(wa);
    i.ws  = 2'(ws);
    return i;
  endfunction

  function automatic int nearest(logic [4:0] r, int c);
    for (int p = c + 1; p <= 3; p++)
      if (r != 0 && pipe[p].wa == r) return p;
    return 0;
  endfunction

  function automatic int fsel(logic [4:0] r, int c);
    int p;
    p = nearest(r, c);
    if (p != 0 && p > int'(pipe[p].ws)) return p;
    return 0;
  endfunction

  function automatic bit pstall(logic [4:0] r, logic [1:0] u);
    int p;
    if (u == 2'd3) return 1'b0;
    p = nearest(r, 0);
    if (p == 1 || p == 2)
      return int'(pipe[p].ws) >= int'(u) + p;
    return 1'b0;
  endfunction

  function automatic exp_t model(instr_t d);
    exp_t x;
    x.stall = pstall(d.ra0, d.u0) || pstall(d.ra1, d.u1);
    x.d0  = 2'(fsel(d.ra0, 0));
    x.d1  = 2'(fsel(d.ra1, 0));
    x.e0  = 2'(fsel(pipe[1].ra0, 1));
    x.e1  = 2'(fsel(pipe[1].ra1, 1));
    x.m1  = 2'(fsel(pipe[2].ra1, 2));
    x.cnt = 32'(mcnt);
    return x;
  endfunction

  task automatic clear_model();
    for (int p = 1; p <= 3; p++) pipe[p] = '0;
    mcnt = 0;
  endtask

  task automatic step(input instr_t ins, input logic rst,
                      output logic st);
    exp_t x;
    hif.dec_read_addr0  = ins.ra0;
    hif.dec_read_stage0 = ins.u0;
    hif.dec_read_addr1  = ins.ra1;
    hif.dec_read_stage1 = ins.u1;
    hif.dec_write_addr  = ins.wa;
    hif.dec_write_stage = ins.ws;
    reset = rst;
    x = model(ins);
    sb.push_back(x);
    st = x.stall;
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      if (x.stall && mcnt < 64'h0_FFFF_FFFF) mcnt++;
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = x.stall ? '0 : ins;
    end
    #1;
  endtask

  task automatic do_reset();
    hif.dec_read_addr0  = '0;
    hif.dec_read_stage0 = '0;
    hif.dec_read_addr1  = '0;
    hif.dec_read_stage1 = '0;
    hif.dec_write_addr  = '0;
    hif.dec_write_stage = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // Issue iq in order, holding the head in D while stalled.
  task automatic run_seq();
    logic st;
    int n;
    n = 0;
    repeat (3) iq.push_back('0);
    while (iq.size() != 0 && n < 2000) begin
      step(iq[0], 1'b0, st);
      if (!st) iq.delete(0);
      n++;
    end
    chk("seq_done", 32'(iq.size()), 32'd0);
    iq.delete();
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mx = sb.pop_front();
      chk("stall", 32'(hif.stall), 32'(mx.stall));
      chk("fwd_d0", 32'(hif.fwd_d0), 32'(mx.d0));
      chk("fwd_d1", 32'(hif.fwd_d1), 32'(mx.d1));
      chk("fwd_e0", 32'(hif.fwd_e0), 32'(mx.e0));
      chk("fwd_e1", 32'(hif.fwd_e1), 32'(mx.e1));
      chk("fwd_m1", 32'(hif.fwd_m1), 32'(mx.m1));
`ifdef HAZARD_STAT_EN
      chk("stall_count", stall_count, mx.cnt);
`endif
    end
  end

  instr_t lw1, beq1, nop;
  logic st;

  initial begin
    nop  = '0;
    lw1  = mk(0, 1, 0, 3, 1, 2);
    beq1 = mk(1, 0, 0, 0, 0, 0);
    do_reset();
    // reset state with idle inputs
    step(nop, 1'b0, st);

    iq.push_back(mk(2, 1, 3, 1, 1, 1));
    iq.push_back(mk(1, 1, 1, 1, 4, 1));
    run_seq();

    do_reset();
    iq.push_back(lw1);
    iq.push_back(beq1);
    run_seq();
`ifdef HAZARD_STAT_EN
    chk("count_after_lw_beq", stall_count, 32'd2);
`endif
    do_reset();
`ifdef HAZARD_STAT_EN
    chk("count_after_reset", stall_count, 32'd0);
`endif

    iq.push_back(lw1);
    iq.push_back(mk(1, 1, 2, 1, 4, 1));
    iq.push_back(mk(1, 1, 2, 1, 31, 1));
    iq.push_back(mk(31, 0, 0, 3, 0, 0));
    iq.push_back(mk(0, 3, 0, 3, 31, 0));
    iq.push_back(mk(31, 0, 0, 3, 0, 0));
    iq.push_back(lw1);
    iq.push_back(mk(0, 1, 1, 2, 0, 0));
    iq.push_back(mk(1, 1, 1, 1, 0, 1));
    iq.push_back(mk(0, 0, 0, 0, 0, 0));
    run_seq();

    // reset asserted during a load->branch stall
    do_reset();
    step(lw1, 1'b0, st);
    step(beq1, 1'b0, st);
    chk("stall_before_reset", 32'(hif.stall), 32'd1);
    step(beq1, 1'b1, st);
    step(beq1, 1'b0, st);
    reset = 1'b0;
    run_seq();

    for (int k = 0; k < 400; k++)
      iq.push_back(mk($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2)));
    run_seq();

    for (int k = 0; k < 200; k++)
      iq.push_back(mk($urandom_range(0, 31), $urandom_range(0, 3),
                      $urandom_range(0, 31), $urandom_range(0, 3),
                      $urandom_range(0, 1) * 31,
                      $urandom_range(0, 2)));
    run_seq();

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
